sy_dpram_be: RTL and testbench

Parametrised successor to the team's simple synchronous dual-port RAM: one write port (B) with byte enables, one read port (A). It adds:
- a selectable read-during-write policy with collision reporting;
- an optional output pipeline register with a valid strobe;
- a post-reset memory-clear sequencer.

It sits between datapath producers and consumers as line or packet buffer storage wherever a single-clock, one-write/one-read RAM is needed.

---
 rtl/sy_dpram_pkg.sv | 22 ++
 rtl/sy_dpram_clr.sv | 51 +++++
 rtl/sy_dpram_be.sv | 153 +++++++++++++++
 tb/tb_sy_dpram_be.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sy_dpram_pkg.sv
// Shared types and helpers for the byte-enabled single-clock dual-port RAM.
package sy_dpram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Address bits needed to index n words (minimum 1).
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sy_dpram_clr.sv
// Post-reset clear sequencer: sweeps zero words over every address, then runs.
module sy_dpram_clr
    import sy_dpram_pkg::*;
#(
    parameter int DP = 64,
    parameter int AD = clogb2(DP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AD-1:0] clr_addr
);

    localparam logic [AD-1:0] LAST_ADDR = AD'(DP - 1);

    state_t        state_reg, state_next;
    logic [AD-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_reg;

endmodule

// File: rtl/sy_dpram_be.sv
// Single-clock RAM: byte-enabled write port B, read port A, selectable
// read-during-write policy, optional output register and post-reset clear.
module sy_dpram_be
    import sy_dpram_pkg::*;
#(
    parameter int WD       = 32,
    parameter int BW       = 8,
    parameter int DP       = 64,
    parameter int AD       = clogb2(DP),
    parameter int RDW_MODE = RDW_OLD,
    parameter int OREG     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             wr_n,
    input  logic             rd_n,
    input  logic [AD-1:0]    addr_b,
    input  logic [WD-1:0]    din_b,
    input  logic [WD/BW-1:0] be_b,
    input  logic [AD-1:0]    addr_a,
    output logic [WD-1:0]    dout_a,
    output logic             dout_vld,
    output logic             coll,
    output logic             busy
);

    localparam int          NB    = WD / BW;
    localparam logic [AD:0] DEPTH = (AD + 1)'(DP);

    logic          clr_we;
    logic [AD-1:0] clr_addr;

    sy_dpram_clr #(
        .DP (DP),
        .AD (AD)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic wr_in_range, rd_in_range, wr_qual, rd_qual, coll_hit;

    assign wr_in_range = ({1'b0, addr_b} < DEPTH);
    assign rd_in_range = ({1'b0, addr_a} < DEPTH);
    assign wr_qual     = ~busy & ~cs_n & ~wr_n & wr_in_range;
    assign rd_qual     = ~busy & ~cs_n & ~rd_n;
    // Collision is judged on address match alone, so be_b = 0 still flags it.
    assign coll_hit    = wr_qual & rd_qual & rd_in_range & (addr_a == addr_b);

    logic [AD-1:0] mem_waddr;
    logic [WD-1:0] mem_wdata;
    logic [NB-1:0] mem_we;

    always_comb begin
        mem_waddr = addr_b;
        mem_wdata = din_b;
        mem_we    = be_b & {NB{wr_qual}};
        if (busy) begin
            mem_waddr = clr_addr;
            mem_wdata = '0;
            mem_we    = {NB{clr_we}};
        end
    end

    // Read-side side-band: held with the read word so dout_a stays stable
    // between reads; strobe and collision flag are one-cycle pulses.
    logic          oor_reg, fwd_sel_reg, vld1_reg, coll1_reg;
    logic [WD-1:0] fwd_data_reg;
    logic [NB-1:0] fwd_be_reg;
    logic [WD-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            oor_reg      <= 1'b0;
            fwd_sel_reg  <= 1'b0;
            fwd_data_reg <= '0;
            fwd_be_reg   <= '0;
            vld1_reg     <= 1'b0;
            coll1_reg    <= 1'b0;
        end else begin
            vld1_reg  <= rd_qual;
            coll1_reg <= coll_hit;
            if (rd_qual) begin
                oor_reg      <= ~rd_in_range;
                fwd_sel_reg  <= coll_hit && (RDW_MODE == RDW_NEW);
                fwd_data_reg <= din_b;
                fwd_be_reg   <= be_b;
            end
        end
    end

    // One RAM per byte lane; the registered read naturally yields old data
    // on a same-address write, and the lane mux applies forwarding.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [BW-1:0] mem [DP];
        logic [BW-1:0] q_reg;

        always_ff @(posedge clk) begin
            if (mem_we[gi]) begin
                mem[mem_waddr] <= mem_wdata[gi*BW +: BW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_reg <= '0;
            end else if (rd_qual && rd_in_range) begin
                q_reg <= mem[addr_a];
            end
        end

        always_comb begin
            s1_data[gi*BW +: BW] = q_reg;
            if (oor_reg) begin
                s1_data[gi*BW +: BW] = '0;
            end else if (fwd_sel_reg && fwd_be_reg[gi]) begin
                s1_data[gi*BW +: BW] = fwd_data_reg[gi*BW +: BW];
            end
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [WD-1:0] dout_reg;
        logic          vld2_reg, coll2_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_reg  <= '0;
                vld2_reg  <= 1'b0;
                coll2_reg <= 1'b0;
            end else begin
                vld2_reg  <= vld1_reg;
                coll2_reg <= vld1_reg & coll1_reg;
                if (vld1_reg) begin
                    dout_reg <= s1_data;
                end
            end
        end

        assign dout_a   = dout_reg;
        assign dout_vld = vld2_reg;
        assign coll     = coll2_reg;
    end else begin : g_noreg
        assign dout_a   = s1_data;
        assign dout_vld = vld1_reg;
        assign coll     = coll1_reg;
    end

endmodule

// File: tb/tb_sy_dpram_be.sv
// Directed bench: four RAM configurations share one stimulus stream.
module tb_sy_dpram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, wr_n, rd_n;
    logic [5:0]  addr_b, addr_a;
    logic [31:0] din_b;
    logic [3:0]  be_b;

    // 0: DP64 old/OREG0  1: DP64 new/OREG0  2: DP64 old/OREG1  3: DP48 new/OREG1
    logic [31:0] dout [4];
    logic        vld  [4];
    logic        coll [4];
    logic        busy [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sy_dpram_be #(.DP(64), .RDW_MODE(0), .OREG(0)) u0 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .addr_a(addr_a),
        .dout_a(dout[0]), .dout_vld(vld[0]), .coll(coll[0]), .busy(busy[0]));
    sy_dpram_be #(.DP(64), .RDW_MODE(1), .OREG(0)) u1 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .addr_a(addr_a),
        .dout_a(dout[1]), .dout_vld(vld[1]), .coll(coll[1]), .busy(busy[1]));
    sy_dpram_be #(.DP(64), .RDW_MODE(0), .OREG(1)) u2 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .addr_a(addr_a),
        .dout_a(dout[2]), .dout_vld(vld[2]), .coll(coll[2]), .busy(busy[2]));
    sy_dpram_be #(.DP(48), .RDW_MODE(1), .OREG(1)) u3 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .addr_a(addr_a),
        .dout_a(dout[3]), .dout_vld(vld[3]), .coll(coll[3]), .busy(busy[3]));

    typedef struct {
        logic        cs_n, wr_n, rd_n;
        logic [5:0]  addr_b;
        logic [31:0] din_b;
        logic [3:0]  be_b;
        logic [5:0]  addr_a;
        logic [31:0] exp0, exp1;
        logic        vld, coll;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
        addr_b = a; din_b = d; be_b = be;
        tick();
        idle();
    endtask

    // Read once; u0 answers after one edge, u3 after two.
    task automatic rd_chk(input string nm, input logic [5:0] a,
                          input logic [31:0] e0, input logic [31:0] e3);
        cs_n = 1'b0; wr_n = 1'b1; rd_n = 1'b0; addr_a = a;
        tick();
        idle();
        chk({nm, " u0 dout"}, dout[0], e0);
        chk({nm, " u0 vld"}, 32'(vld[0]), 32'd1);
        tick();
        chk({nm, " u3 dout"}, dout[3], e3);
        chk({nm, " u3 vld"}, 32'(vld[3]), 32'd1);
    endtask

    task automatic wait_clear(input string nm);
        int c0, c3;
        c0 = 0; c3 = 0;
        for (int n = 1; n <= 200 && (c0 == 0 || c3 == 0); n++) begin
            tick();
            if (c0 == 0 && !busy[0]) c0 = n;
            if (c3 == 0 && !busy[3]) c3 = n;
        end
        chk({nm, " clear cycles DP64"}, 32'(c0), 32'd64);
        chk({nm, " clear cycles DP48"}, 32'(c3), 32'd48);
    endtask

    initial begin
        //           cs wr rd ab     din            be    aa     exp0           exp1           vld  coll
        tbl[0]  = '{1'b0,1'b0,1'b1,6'd5,32'hAABBCCDD,4'hF,6'd0,32'h00000000,32'h00000000,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b1,6'd5,32'h11223344,4'h5,6'd0,32'h00000000,32'h00000000,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,6'd0,32'h00000000,4'h0,6'd5,32'hAA22CC44,32'hAA22CC44,1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,6'd5,32'hFFFFFFFF,4'hF,6'd5,32'hAA22CC44,32'hAA22CC44,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,6'd0,32'h00000000,4'h0,6'd5,32'hAA22CC44,32'hAA22CC44,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,6'd9,32'hFFFFFFFF,4'h3,6'd9,32'h00000000,32'h0000FFFF,1'b1,1'b1};
        tbl[6]  = '{1'b0,1'b1,1'b0,6'd0,32'h00000000,4'h0,6'd9,32'h0000FFFF,32'h0000FFFF,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,6'd5,32'h00000000,4'h0,6'd5,32'hAA22CC44,32'hAA22CC44,1'b1,1'b1};
        tbl[8]  = '{1'b0,1'b0,1'b0,6'd5,32'h12345678,4'hF,6'd6,32'h00000000,32'h00000000,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,6'd0,32'h00000000,4'h0,6'd5,32'h12345678,32'h12345678,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,6'd7,32'hCAFEBABE,4'hF,6'd7,32'h00000000,32'hCAFEBABE,1'b1,1'b1};
        tbl[11] = '{1'b1,1'b1,1'b1,6'd0,32'h00000000,4'h0,6'd0,32'h00000000,32'hCAFEBABE,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,6'd0,32'h00000000,4'h0,6'd7,32'hCAFEBABE,32'hCAFEBABE,1'b1,1'b0};

        rst = 1'b1; idle();
        addr_b = '0; addr_a = '0; din_b = '0; be_b = '0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset busy%0d", k), 32'(busy[k]), 32'd1);
            chk($sformatf("reset dout%0d", k), dout[k], 32'h0);
            chk($sformatf("reset vld%0d", k), 32'(vld[k]), 32'd0);
            chk($sformatf("reset coll%0d", k), 32'(coll[k]), 32'd0);
        end

        rst = 1'b0;
        wait_clear("initial");

        // Whole array reads back zero at latency 1, pipelined.
        for (int a = 0; a < 64; a++) begin
            cs_n = 1'b0; rd_n = 1'b0; addr_a = 6'(a);
            tick();
            chk($sformatf("sweep a%0d dout", a), dout[0], 32'h0);
            chk($sformatf("sweep a%0d vld", a), 32'(vld[0]), 32'd1);
        end
        idle();

        for (int i = 0; i < 13; i++) begin
            cs_n = tbl[i].cs_n; wr_n = tbl[i].wr_n; rd_n = tbl[i].rd_n;
            addr_b = tbl[i].addr_b; din_b = tbl[i].din_b; be_b = tbl[i].be_b;
            addr_a = tbl[i].addr_a;
            tick();
            chk($sformatf("row%0d dout0", i), dout[0], tbl[i].exp0);
            chk($sformatf("row%0d vld0", i), 32'(vld[0]), 32'(tbl[i].vld));
            chk($sformatf("row%0d coll0", i), 32'(coll[0]), 32'(tbl[i].coll));
            chk($sformatf("row%0d dout1", i), dout[1], tbl[i].exp1);
            chk($sformatf("row%0d vld1", i), 32'(vld[1]), 32'(tbl[i].vld));
            chk($sformatf("row%0d coll1", i), 32'(coll[1]), 32'(tbl[i].coll));
        end
        idle();

        // OREG=1: four back-to-back reads give four consecutive strobes at latency 2.
        for (int a = 0; a < 4; a++) wr(6'(a), 32'h100 + 32'(a), 4'hF);
        for (int j = 1; j <= 6; j++) begin
            if (j <= 4) begin
                cs_n = 1'b0; rd_n = 1'b0; addr_a = 6'(j - 1);
            end else begin
                idle();
            end
            tick();
            chk($sformatf("oreg t%0d vld2", j), 32'(vld[2]), (j >= 2 && j <= 5) ? 32'd1 : 32'd0);
            if (j >= 2 && j <= 5)
                chk($sformatf("oreg t%0d dout2", j), dout[2], 32'h100 + 32'(j - 2));
        end
        cs_n = 1'b1; rd_n = 1'b0; addr_a = 6'd0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("oreg hold%0d dout2", j), dout[2], 32'h103);
            chk($sformatf("oreg hold%0d vld2", j), 32'(vld[2]), 32'd0);
        end
        idle();

        // DP=48: address 50 is out of range and must not alias onto low words.
        wr(6'd50, 32'hDEADBEEF, 4'hF);
        rd_chk("oor50", 6'd50, 32'hDEADBEEF, 32'h0);
        rd_chk("alias2", 6'd2, 32'h102, 32'h102);

        // Reset in RUN: pipeline flushed, busy rises, array re-zeroed.
        wr(6'd10, 32'h5A5A5A5A, 4'hF);
        cs_n = 1'b0; rd_n = 1'b0; addr_a = 6'd10;
        tick();
        idle();
        chk("pre-rst dout0", dout[0], 32'h5A5A5A5A);
        rst = 1'b1;
        tick();
        chk("mid-rst vld2 flushed", 32'(vld[2]), 32'd0);
        chk("mid-rst busy0", 32'(busy[0]), 32'd1);
        chk("mid-rst busy3", 32'(busy[3]), 32'd1);
        chk("mid-rst dout0", dout[0], 32'h0);
        rst = 1'b0;
        wait_clear("rerun");
        rd_chk("rezero10", 6'd10, 32'h0, 32'h0);
        rd_chk("rezero5", 6'd5, 32'h0, 32'h0);
        rd_chk("rezero2", 6'd2, 32'h0, 32'h0);
        rd_chk("rezero50", 6'd50, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
